// File: rtl/demux_stream_router_pkg.sv
// Shared constants and the onehot helper used by the stream router and
// by any decoder that needs a range-checked onehot of a channel index.
package demux_stream_pkg;

    localparam int MAX_OUT   = 64;
    localparam int MAX_SEL_W = 6;

    // InBcast encoding
    localparam logic MODE_UNICAST = 1'b0;
    localparam logic MODE_BCAST   = 1'b1;

    // Returns {valid, mask}: mask is onehot(sel) when sel < n, else all zero
    // with valid cleared. Width is fixed at MAX_OUT; callers slice to size.
    function automatic logic [MAX_OUT:0] f_onehot(input logic [MAX_SEL_W-1:0] sel,
                                                  input int unsigned          n);
        logic [MAX_OUT-1:0] mask;
        logic               valid;
        mask  = '0;
        valid = 1'b0;
        if (32'(sel) < n) begin
            mask[sel] = 1'b1;
            valid     = 1'b1;
        end
        return {valid, mask};
    endfunction

endpackage

// File: rtl/demux_stream_router_if.sv
// Handshake bundle between a stream source and the router, plus the
// router's status outputs. slave = router side, master = source side.
interface demux_stream_router_if #(
    parameter int NUM_OUT = 16,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
);
    localparam int SEL_W = $clog2(NUM_OUT);

    logic                      enable;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_data;
    logic [SEL_W-1:0]          in_sel;
    logic                      in_bcast;
    logic [NUM_OUT-1:0]        bcast_mask;
    logic [NUM_OUT-1:0]        out_valid;
    logic [NUM_OUT-1:0]        out_ready;
    logic [NUM_OUT*DATA_W-1:0] out_data;
    logic                      busy;
    logic                      sel_err;
    logic [CNT_W-1:0]          drop_count;

    modport slave (
        input  enable, in_valid, in_data, in_sel, in_bcast, bcast_mask, out_ready,
        output in_ready, out_valid, out_data, busy, sel_err, drop_count
    );

    modport master (
        output enable, in_valid, in_data, in_sel, in_bcast, bcast_mask, out_ready,
        input  in_ready, out_valid, out_data, busy, sel_err, drop_count
    );
endinterface

// File: rtl/demux_stream_router_decode.sv
// Combinational channel decoder: index -> onehot plus out-of-range flag.
// Out-of-range can only occur when NUM_OUT is not a power of two.
module demux_onehot_decode
    import demux_stream_pkg::*;
#(
    parameter int NUM_OUT = 16,
    parameter int SEL_W   = $clog2(NUM_OUT)
) (
    input  logic [SEL_W-1:0]   sel_i,
    output logic [NUM_OUT-1:0] onehot_o,
    output logic               oor_o
);
    logic [MAX_OUT:0] dec;

    assign dec      = f_onehot(MAX_SEL_W'(sel_i), NUM_OUT);
    assign onehot_o = dec[NUM_OUT-1:0];

    generate
        if (NUM_OUT < MAX_OUT) begin : g_pad
            // Bits above NUM_OUT are always zero; folding them in keeps the
            // whole helper result consumed without changing the flag.
            assign oor_o = ~dec[MAX_OUT] | (|dec[MAX_OUT-1:NUM_OUT]);
        end else begin : g_full
            assign oor_o = ~dec[MAX_OUT];
        end
    endgenerate
endmodule

// File: rtl/demux_stream_router.sv
// Registered 1-to-NUM_OUT stream router. One word is held until every
// addressed channel has taken it; a new word may be accepted in the same
// cycle the last outstanding channel completes (OutReady -> InReady is
// combinational on purpose, giving one word per cycle).
module demux_stream_router
    import demux_stream_pkg::*;
#(
    parameter int NUM_OUT = 16,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    demux_stream_router_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_OUT);

    logic [NUM_OUT-1:0] pending_q, pending_d;
    logic [DATA_W-1:0]  held_q, held_d;
    logic               sel_err_q, sel_err_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    logic [NUM_OUT-1:0] uni_mask;
    logic [NUM_OUT-1:0] new_mask;
    logic               sel_oor;
    logic               last;
    logic               in_ready;
    logic               accept;
    logic               drop;

    demux_onehot_decode #(
        .NUM_OUT (NUM_OUT),
        .SEL_W   (SEL_W)
    ) u_dec (
        .sel_i    (bus.in_sel),
        .onehot_o (uni_mask),
        .oor_o    (sel_oor)
    );

    // Every still-pending channel completes this cycle
    assign last     = ((pending_q & ~bus.out_ready) == '0);
    assign in_ready = bus.enable & ~rst_i & last;
    assign accept   = bus.in_valid & in_ready;
    assign new_mask = (bus.in_bcast == MODE_BCAST) ? bus.bcast_mask : uni_mask;
    // An accepted word with no destination is discarded and counted
    assign drop     = accept & (new_mask == '0);

    // Next state: retire handshaked channels, or replace with a new word
    always_comb begin
        pending_d = pending_q & ~bus.out_ready;
        held_d    = held_q;
        sel_err_d = accept & (bus.in_bcast == MODE_UNICAST) & sel_oor;
        drop_d    = drop_q;
        if (accept) begin
            pending_d = new_mask;
            held_d    = bus.in_data;
        end
        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // State registers with synchronous reset; reset discards the held word
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
            held_q    <= '0;
            sel_err_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            pending_q <= pending_d;
            held_q    <= held_d;
            sel_err_q <= sel_err_d;
            drop_q    <= drop_d;
        end
    end

    // Outputs are masked while reset is asserted so nothing leaks that cycle
    generate
        for (genvar i = 0; i < NUM_OUT; i++) begin : g_ch
            assign bus.out_valid[i] = pending_q[i] & ~rst_i;
            assign bus.out_data[i*DATA_W +: DATA_W] =
                (pending_q[i] & ~rst_i) ? held_q : '0;
        end
    endgenerate

    assign bus.in_ready   = in_ready;
    assign bus.busy       = (|pending_q) & ~rst_i;
    assign bus.sel_err    = sel_err_q;
    assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_demux_stream_router.sv
// Scoreboard bench: NUM_OUT=12 (non power of two) and a 4-bit drop counter
// so out-of-range selects and saturation are both reachable.
module tb_demux_stream_router;
    localparam int N  = 12;
    localparam int DW = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux_stream_router_if #(.NUM_OUT(N), .DATA_W(DW), .CNT_W(CW)) bus();

    demux_stream_router #(.NUM_OUT(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Reference model: one queue of words still owed to each channel
    logic [DW-1:0] q [N][$];
    int  exp_drop = 0;
    bit  exp_sel  = 0;
    bit  mon_en   = 0;
    int  total    = 0;
    int  bad      = 0;

    function automatic logic [N-1:0] pend();
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = (q[i].size() != 0);
        return p;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // One clock cycle of stimulus; model updates at the active edge
    task automatic cyc(input bit en, input bit v, input logic [DW-1:0] d, input int sel,
                       input bit bc, input logic [N-1:0] m, input logic [N-1:0] rdy,
                       input bit r);
        bit erdy;
        logic [N-1:0] mask;
        @(negedge clk);
        rst            = r;
        bus.enable     = en;
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.in_sel     = sel[3:0];
        bus.in_bcast   = bc;
        bus.bcast_mask = m;
        bus.out_ready  = rdy;
        #1;
        erdy = en && !r && ((pend() & ~rdy) == '0);
        check("in_ready", bus.in_ready, erdy);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < N; i++) q[i].delete();
            exp_drop = 0;
            exp_sel  = 0;
        end else begin
            exp_sel = 0;
            if (v && erdy) begin
                mask = bc ? m : ((sel < N) ? N'(1 << sel) : '0);
                if (mask == '0) begin
                    if (exp_drop < (1 << CW) - 1) exp_drop++;
                    exp_sel = !bc;
                end else begin
                    for (int i = 0; i < N; i++) if (mask[i]) q[i].push_back(d);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1, 0, 8'h00, 0, 0, '0, '1, 0);
    endtask

    // Monitor: compares visible outputs against the model and retires handshakes
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                logic [N-1:0] ev;
                ev = rst ? '0 : pend();
                check("out_valid", bus.out_valid, ev);
                for (int i = 0; i < N; i++) begin
                    check($sformatf("out_data[%0d]", i), bus.out_data[i*DW +: DW],
                          ev[i] ? q[i][0] : 8'h00);
                    if (ev[i] && bus.out_ready[i]) void'(q[i].pop_front());
                end
                check("busy", bus.busy, ev != '0);
                check("sel_err", bus.sel_err, exp_sel);
                check("drop_count", bus.drop_count, exp_drop);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.enable = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sel = '0;
        bus.in_bcast = 1'b0; bus.bcast_mask = '0; bus.out_ready = '0;
        cyc(0, 0, 8'h00, 0, 0, '0, '0, 1);
        mon_en = 1;
        cyc(0, 0, 8'h00, 0, 0, '0, '0, 1);
        idle(2);

        // Unicast sweep; selects 12..15 are out of range and dropped
        for (int i = 0; i < 16; i++) cyc(1, 1, 8'hA0 + 8'(i), i, 0, '0, '1, 0);
        idle(2);

        // Backpressure on channel 5 for 4 cycles, next word waits then goes
        cyc(1, 1, 8'h3C, 5, 0, '0, '1, 0);
        for (int k = 0; k < 4; k++) cyc(1, 1, 8'h11, 2, 0, '0, ~N'(1 << 5), 0);
        cyc(1, 1, 8'h11, 2, 0, '0, '1, 0);
        idle(2);

        // Broadcast to 0,4,7; ready order 0, 7, 4
        cyc(1, 1, 8'h55, 0, 1, 12'h091, '1, 0);
        cyc(1, 0, 8'h00, 0, 0, '0, 12'h001, 0);
        cyc(1, 0, 8'h00, 0, 0, '0, 12'h080, 0);
        cyc(1, 0, 8'h00, 0, 0, '0, 12'h010, 0);
        idle(2);

        // Drops: out-of-range unicast, empty broadcast, then run into saturation
        cyc(1, 1, 8'h77, 13, 0, '0, '1, 0);
        cyc(1, 1, 8'h78, 0, 1, '0, '1, 0);
        idle(1);
        for (int k = 0; k < 20; k++) cyc(1, 1, 8'(k), 12 + (k % 4), k[0], '0, '1, 0);
        idle(2);

        // Reset in the middle of a full broadcast
        cyc(1, 1, 8'hC3, 0, 1, 12'hFFF, '1, 0);
        cyc(1, 0, 8'h00, 0, 0, '0, 12'h007, 0);
        cyc(1, 0, 8'h00, 0, 0, '0, 12'h000, 0);
        cyc(1, 1, 8'h99, 1, 0, '0, 12'h000, 1);
        idle(3);

        // Enable low: no accepts, held word still drains
        cyc(1, 1, 8'h42, 3, 0, '0, '1, 0);
        cyc(0, 1, 8'h43, 4, 0, '0, ~N'(1 << 3), 0);
        cyc(0, 1, 8'h44, 4, 0, '0, '1, 0);
        cyc(0, 1, 8'h45, 4, 0, '0, '1, 0);
        idle(2);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            logic [N-1:0] m, rr;
            m  = ($urandom % 6 == 0) ? '0 : N'($urandom);
            rr = N'($urandom) | N'($urandom);
            cyc(($urandom % 8) != 0, $urandom % 2, 8'($urandom), $urandom % 16,
                ($urandom % 3) == 0, m, rr, ($urandom % 150) == 0);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
